// File: rtl/j_rcount_gen.sv
// Loadable up/down address counter for systolic row/column sequencing.
// Adds a terminal-limit compare, reload from a latched base, and a registered done pulse.
module j_rcount_gen #(
    parameter int WIDTH   = 6,
    parameter int LDSHIFT = 1,
    parameter int STEP    = 1
) (
    input  logic                       clk,
    input  logic                       resetl,
    input  logic                       cnten,
    input  logic                       cntld,
    input  logic [WIDTH-LDSHIFT-1:0]   ldval,
    input  logic [WIDTH-1:0]           limit,
    input  logic                       dir,
    input  logic                       reload,
    output logic [WIDTH-1:0]           count,
    output logic                       tc,
    output logic                       done,
    output logic                       busy
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] ld_full;
    logic [WIDTH-1:0] count_step;

    // Load field sits at count[WIDTH-1:LDSHIFT]; the low LDSHIFT bits are zero.
    assign ld_full    = WIDTH'(ldval) << LDSHIFT;
    assign count_step = dir ? (count - STEP_W) : (count + STEP_W);
    assign tc         = (count == limit);

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            count <= '0;
            base  <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
        end else if (cntld) begin
            count <= ld_full;
            base  <= ld_full;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (cnten && busy) begin
            if (tc) begin
                // Terminal event: either restart the pass from base or park at the limit.
                done <= 1'b1;
                if (reload) begin
                    count <= base;
                end else begin
                    busy <= 1'b0;
                end
            end else begin
                count <= count_step;
                done  <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_j_rcount_gen.sv
// Scoreboard bench for j_rcount_gen: two instances (STEP=1 and STEP=2) share stimulus.
// A behavioural model pushes expectations; a monitor pops and compares every cycle.
module tb_j_rcount_gen;

    localparam int WIDTH = 6;
    localparam int LDSHIFT = 1;
    localparam int MOD = 64;

    logic clk = 1'b0;
    logic resetl = 1'b0;
    logic cnten = 1'b0;
    logic cntld = 1'b0;
    logic [WIDTH-LDSHIFT-1:0] ldval = '0;
    logic [WIDTH-1:0] limit = '0;
    logic dir = 1'b0;
    logic reload = 1'b0;

    logic [WIDTH-1:0] count0, count1;
    logic tc0, tc1, done0, done1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    j_rcount_gen #(.WIDTH(WIDTH), .LDSHIFT(LDSHIFT), .STEP(1)) u_dut0 (
        .clk(clk), .resetl(resetl), .cnten(cnten), .cntld(cntld), .ldval(ldval),
        .limit(limit), .dir(dir), .reload(reload),
        .count(count0), .tc(tc0), .done(done0), .busy(busy0)
    );

    j_rcount_gen #(.WIDTH(WIDTH), .LDSHIFT(LDSHIFT), .STEP(2)) u_dut1 (
        .clk(clk), .resetl(resetl), .cnten(cnten), .cntld(cntld), .ldval(ldval),
        .limit(limit), .dir(dir), .reload(reload),
        .count(count1), .tc(tc1), .done(done1), .busy(busy1)
    );

    typedef struct packed {
        logic [5:0] cnt0;
        logic       done0;
        logic       busy0;
        logic [5:0] cnt1;
        logic       done1;
        logic       busy1;
    } exp_t;

    exp_t sb_q[$];

    int m_cnt[2];
    int m_base[2];
    bit m_busy[2];
    bit m_done[2];
    int m_step[2] = '{1, 2};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_base[i] = 0;
            m_busy[i] = 1'b1;
            m_done[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit ld, input bit en, input bit d, input bit rl,
                              input int lv, input int lim);
        for (int i = 0; i < 2; i++) begin
            if (ld) begin
                m_cnt[i] = (lv * (2 ** LDSHIFT)) % MOD;
                m_base[i] = m_cnt[i];
                m_busy[i] = 1'b1;
                m_done[i] = 1'b0;
            end else if (en && m_busy[i]) begin
                if (m_cnt[i] == lim) begin
                    m_done[i] = 1'b1;
                    if (rl) m_cnt[i] = m_base[i];
                    else m_busy[i] = 1'b0;
                end else begin
                    m_done[i] = 1'b0;
                    if (d) m_cnt[i] = (m_cnt[i] - m_step[i] + MOD) % MOD;
                    else m_cnt[i] = (m_cnt[i] + m_step[i]) % MOD;
                end
            end else begin
                m_done[i] = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive at negedge, predict, return just after the rising edge.
    task automatic cyc(input bit ld, input bit en, input bit d, input bit rl,
                       input int lv, input int lim);
        exp_t e;
        @(negedge clk);
        cntld = ld;
        cnten = en;
        dir = d;
        reload = rl;
        ldval = lv[WIDTH-LDSHIFT-1:0];
        limit = lim[WIDTH-1:0];
        model_step(ld, en, d, rl, lv, lim);
        e.cnt0 = m_cnt[0][5:0];
        e.done0 = m_done[0];
        e.busy0 = m_busy[0];
        e.cnt1 = m_cnt[1][5:0];
        e.done1 = m_done[1];
        e.busy1 = m_busy[1];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_count0", int'(count0), int'(e.cnt0));
            chk("sb_done0", int'(done0), int'(e.done0));
            chk("sb_busy0", int'(busy0), int'(e.busy0));
            chk("sb_tc0", int'(tc0), int'(e.cnt0 == limit));
            chk("sb_count1", int'(count1), int'(e.cnt1));
            chk("sb_done1", int'(done1), int'(e.done1));
            chk("sb_busy1", int'(busy1), int'(e.busy1));
            chk("sb_tc1", int'(tc1), int'(e.cnt1 == limit));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim_hold;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetl = 1'b1;

        // Basic up count from a load.
        cyc(1, 0, 0, 0, 5, 63);
        chk("load_count", int'(count0), 10);
        cyc(0, 1, 0, 0, 0, 63);
        chk("up_11", int'(count0), 11);
        cyc(0, 1, 0, 0, 0, 63);
        chk("up_12", int'(count0), 12);
        cyc(0, 1, 0, 0, 0, 63);
        chk("up_13", int'(count0), 13);
        chk("up_done", int'(done0), 0);

        // Down count through the natural wrap.
        cyc(1, 0, 1, 0, 0, 40);
        chk("dn_load", int'(count0), 0);
        cyc(0, 1, 1, 0, 0, 40);
        chk("dn_wrap", int'(count0), 63);
        chk("dn_wrap_done", int'(done0), 0);
        cyc(0, 1, 1, 0, 0, 40);
        chk("dn_62", int'(count0), 62);

        // Terminal with reload.
        cyc(1, 0, 0, 1, 2, 7);
        chk("rl_load", int'(count0), 4);
        for (int i = 5; i <= 7; i++) begin
            cyc(0, 1, 0, 1, 0, 7);
            chk("rl_count", int'(count0), i);
            chk("rl_done_low", int'(done0), 0);
        end
        chk("rl_tc", int'(tc0), 1);
        cyc(0, 1, 0, 1, 0, 7);
        chk("rl_back_base", int'(count0), 4);
        chk("rl_done", int'(done0), 1);
        chk("rl_busy", int'(busy0), 1);
        cyc(0, 1, 0, 1, 0, 7);
        chk("rl_done_once", int'(done0), 0);

        // Terminal with stop.
        cyc(1, 0, 0, 0, 2, 7);
        repeat (3) cyc(0, 1, 0, 0, 0, 7);
        cyc(0, 1, 0, 0, 0, 7);
        chk("st_count", int'(count0), 7);
        chk("st_busy", int'(busy0), 0);
        chk("st_done", int'(done0), 1);
        cyc(0, 1, 0, 0, 0, 7);
        chk("st_hold", int'(count0), 7);
        chk("st_done_once", int'(done0), 0);
        cyc(1, 0, 0, 0, 1, 7);
        chk("st_reload_count", int'(count0), 2);
        chk("st_reload_busy", int'(busy0), 1);

        // Load priority and STEP=2 on the second instance.
        cyc(1, 0, 0, 1, 2, 6);
        cyc(0, 1, 0, 1, 0, 6);
        chk("s2_at_limit", int'(count1), 6);
        chk("s2_tc", int'(tc1), 1);
        cyc(1, 1, 0, 1, 3, 6);
        chk("s2_ld_prio", int'(count1), 6);
        chk("s2_ld_done", int'(done1), 0);
        cyc(0, 1, 0, 1, 0, 10);
        chk("s2_8", int'(count1), 8);
        cyc(0, 1, 0, 1, 0, 10);
        chk("s2_10", int'(count1), 10);
        cyc(0, 1, 0, 1, 0, 10);
        chk("s2_reload", int'(count1), 6);
        chk("s2_done", int'(done1), 1);

        // Asynchronous reset mid-count at 0x15.
        cyc(1, 0, 0, 0, 5, 63);
        repeat (11) cyc(0, 1, 0, 0, 0, 63);
        chk("pre_rst", int'(count0), 21);
        cntld = 1'b0;
        cnten = 1'b0;
        #2;
        resetl = 1'b0;
        #1;
        chk("rst_count0", int'(count0), 0);
        chk("rst_done0", int'(done0), 0);
        chk("rst_busy0", int'(busy0), 1);
        chk("rst_count1", int'(count1), 0);
        model_reset();
        @(negedge clk);
        resetl = 1'b1;

        // Randomized traffic against the model.
        lim_hold = 20;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) lim_hold = $urandom_range(0, 63);
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 31), lim_hold);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
